// File: rtl/axi_write_vector_stream_if.sv
// AXI-Stream bundle carrying one data beat per tvalid && tready handshake.
interface axi_stream_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axi_write_vector_stream.sv
// Serialises variable-length bit vectors onto an AXI-Stream master as
// ceil(len/AXI_DATA_WIDTH) beats, with a valid/ready input handshake,
// back-to-back capture on the final beat and a per-beat valid-bit count.
module axi_write_vector_stream #(
    parameter int MAX_VEC_LENGTH   = 64,
    parameter int AXI_DATA_WIDTH   = 32,
    parameter bit MSB_FIRST        = 1'b0,
    parameter int MAX_VEC_LENGTH_W = (MAX_VEC_LENGTH <= 1) ? 1 : $clog2(MAX_VEC_LENGTH + 1),
    parameter int BEAT_CNT_W       = $clog2(AXI_DATA_WIDTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [MAX_VEC_LENGTH_W-1:0] in_vec_length,
    input  logic [MAX_VEC_LENGTH-1:0]   in_vec,
    input  logic                        in_last,
    axi_stream_if.master                data_out,
    output logic [BEAT_CNT_W-1:0]       out_valid_bits,
    output logic                        err_len_clamped
);

    localparam int W   = AXI_DATA_WIDTH;
    localparam int NB  = (MAX_VEC_LENGTH + W - 1) / W;   // most beats a vector can need
    localparam int PAD = NB * W;                         // capture register padded to whole beats

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q, state_d;
    logic [31:0]      beat_q, beat_d;      // index of the beat on the bus
    logic [31:0]      beats_q, beats_d;    // beats in the current vector
    logic [31:0]      rem_q, rem_d;        // valid bits not yet handshaken
    logic [PAD-1:0]   data_q, data_d;      // masked vector, shifted one beat per handshake
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic             rdy_en_q, rdy_en_d;  // holds in_ready low until the first edge after reset

    logic [31:0]      len32;
    logic [31:0]      len_l;
    logic             over;
    logic [31:0]      beats_new;
    logic [PAD-1:0]   masked;
    logic [PAD-1:0]   cap_data;
    logic             tvalid_c;
    logic             final_beat;
    logic             hs;
    logic             cap;
    logic [W-1:0]     tdata_c;

    // Clamp the offered length, count its beats and build the masked, justified capture image
    always_comb begin
        len32     = 32'(in_vec_length);
        over      = len32 > 32'(MAX_VEC_LENGTH);
        len_l     = over ? 32'(MAX_VEC_LENGTH) : len32;
        beats_new = '0;
        if (len_l == 32'd0) begin
            // An empty vector still needs one beat when it has to close a packet
            beats_new = in_last ? 32'd1 : 32'd0;
        end else begin
            beats_new = (len_l + 32'(W) - 32'd1) / 32'(W);
        end
        masked = '0;
        for (int i = 0; i < MAX_VEC_LENGTH; i++) begin
            if (32'(i) < len_l) begin
                masked[i] = in_vec[i];
            end
        end
        // MSB-first output shifts the vector up so bit L-1 lands at the top of beat 0
        cap_data = MSB_FIRST ? (masked << (32'(PAD) - len_l)) : masked;
    end

    // Next-state logic: beat advance on handshake, reload on capture (capture wins)
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        beats_d    = beats_q;
        rem_d      = rem_q;
        data_d     = data_q;
        last_d     = last_q;
        rdy_en_d   = 1'b1;
        tvalid_c   = (state_q == SEND);
        final_beat = (beat_q == beats_q - 32'd1);
        hs         = tvalid_c && data_out.tready;
        in_ready   = rdy_en_q && ((state_q == IDLE) || (hs && final_beat));
        cap        = in_valid && in_ready;
        err_d      = cap && over;
        if (hs) begin
            beat_d = beat_q + 32'd1;
            rem_d  = rem_q - 32'(W);
            data_d = MSB_FIRST ? (data_q << W) : (data_q >> W);
            if (final_beat) begin
                state_d = IDLE;
            end
        end
        if (cap) begin
            state_d = (beats_new != 32'd0) ? SEND : IDLE;
            beat_d  = '0;
            beats_d = beats_new;
            rem_d   = len_l;
            data_d  = cap_data;
            last_d  = in_last;
        end
    end

    // Beat presentation; everything reads as zero while no beat is offered
    always_comb begin
        tdata_c        = '0;
        out_valid_bits = '0;
        if (tvalid_c) begin
            tdata_c        = MSB_FIRST ? data_q[PAD-1 -: W] : data_q[W-1:0];
            out_valid_bits = final_beat ? BEAT_CNT_W'(rem_q) : BEAT_CNT_W'(W);
        end
    end

    assign data_out.tvalid = tvalid_c;
    assign data_out.tdata  = tdata_c;
    assign data_out.tlast  = tvalid_c && final_beat && last_q;
    assign err_len_clamped = err_q;

    // State, counters and capture register; reset abandons any vector in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            beats_q  <= '0;
            rem_q    <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            beats_q  <= beats_d;
            rem_q    <= rem_d;
            data_q   <= data_d;
            last_q   <= last_d;
            err_q    <= err_d;
            rdy_en_q <= rdy_en_d;
        end
    end

endmodule

// File: doc/axi_write_vector_stream.md
Name: axi_write_vector_stream

Overview:
Serialises variable-length bit vectors onto an AXI-Stream master as ceil(len/AXI_DATA_WIDTH) beats.
- Successor to the single-shot vector writer. Adds a valid/ready input handshake with an internal capture register, back-to-back vectors with no idle cycle, selectable beat order, masking of bits above the vector length, a per-beat valid-bit count sideband, and defined zero-length and over-length handling.
- Sits between solver cores and the DMA/UART result path.

Parameters:
- MAX_VEC_LENGTH, 64, maximum vector length in bits (>=1).
- AXI_DATA_WIDTH, 32, data beat width in bits (>=1).
- MSB_FIRST, 0. 0 = beat 0 carries the low bits of the vector. 1 = beat 0 carries the top valid bits.
- MAX_VEC_LENGTH_W, $clog2(MAX_VEC_LENGTH+1) (1 if MAX_VEC_LENGTH<=1), width of the length field.
- BEAT_CNT_W, $clog2(AXI_DATA_WIDTH+1), width of the valid-bit sideband.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  input vector offered.
- in_ready  out  1  block accepts a vector this cycle.
- in_vec_length  in  MAX_VEC_LENGTH_W  number of valid bits, vec[len-1:0].
- in_vec  in  MAX_VEC_LENGTH  vector payload.
- in_last  in  1  vector is the last of its packet; drives tlast on its final beat.
- data_out  axi_stream_if.master  AXI_DATA_WIDTH  tdata/tvalid/tready/tlast.
- out_valid_bits  out  BEAT_CNT_W  count of meaningful bits in the current beat; qualified by tvalid.
- err_len_clamped  out  1  one-cycle pulse: the accepted length exceeded MAX_VEC_LENGTH.

Behaviour:
Reset:
- Async assert forces state IDLE, beat counter 0, capture register 0.
- Outputs during reset: tvalid=0, tlast=0, tdata=0, out_valid_bits=0, err_len_clamped=0, in_ready=0.
- in_ready rises the first clock edge after reset deassertion.
- Reset mid-packet abandons the remaining beats. tvalid falls asynchronously. No resume.

States:
- IDLE: in_ready=1, tvalid=0.
- SEND: tvalid=1.

Capture:
- On in_valid && in_ready the block registers in_vec, in_last and the clamped length. L = min(in_vec_length, MAX_VEC_LENGTH).
- If in_vec_length > MAX_VEC_LENGTH, err_len_clamped pulses in the cycle after the capture.
- Beats = ceil(L/AXI_DATA_WIDTH), computed in 32-bit arithmetic.
- Bits at index >= L are forced to 0 in the captured copy.

Latency:
- Capture at edge N puts the first beat on the bus (tvalid=1) in the cycle after edge N.

Beat content, with W = AXI_DATA_WIDTH:
- MSB_FIRST=0: beat k tdata = masked_vec[k*W +: W]. The vector is zero-padded above MAX_VEC_LENGTH.
- MSB_FIRST=1: the vector is left-justified so vec[L-1] lands at tdata[W-1] of beat 0. Subsequent beats continue downward. The final beat is zero-filled in its low bits.
- out_valid_bits = W on every beat except the last, which carries L - (beats-1)*W.

Handshake:
- tdata, tlast and out_valid_bits are held stable while tvalid && !tready.
- The beat counter advances only on tvalid && tready.
- tlast = 1 only on the final beat of a vector captured with in_last=1.

Transitions:
- IDLE -> SEND on a capture with beats>0.
- SEND -> IDLE on the final-beat handshake when no new vector is captured in that cycle.
- SEND -> SEND on the final-beat handshake when a new vector is captured in that cycle.

Back-to-back:
- in_ready = (state==IDLE) || (tvalid && tready && final beat).
- This is a combinational path from tready. With in_valid held high, the next vector's first beat follows with no bubble.

Zero length (L=0):
- With in_last=0: consumed, no beat emitted, stays IDLE.
- With in_last=1: emits one beat with tdata=0, out_valid_bits=0, tlast=1. This closes the packet.

Simultaneous events:
- A capture and final-beat handshake in the same cycle loads the new vector and resets the beat counter to 0.

Test Plan:
1. W=32, MAX=64, MSB_FIRST=0. Send len=40, vec=0xFFFF_FFFF_FFFF_FFFF, last=1. Expect 2 beats: 0xFFFFFFFF with out_valid_bits=32, tlast=0; then 0x000000FF with out_valid_bits=8, tlast=1.
2. Same vector with MSB_FIRST=1 and vec=0x00_AB_CDEF_0123 (len=40). Expect beat0 = 0xABCDEF01, beat1 = 0x23000000 with out_valid_bits=8, tlast=1.
3. Back-to-back, in_valid held high. Send lengths 32, 33, 1 with last flags 0, 0, 1. Expect 4 consecutive beats with tvalid continuously high and tlast only on beat 4. in_ready pulses exactly on beats 1, 3 and 4.
4. Random tready (~50%) with len=64. Expect tdata stable while stalled, exactly 2 beats, and no capture while the first beat is pending.
5. Zero length: len=0 with last=0 emits no beat and in_ready stays 1. Then len=0 with last=1 emits a single beat with tdata=0, tlast=1, out_valid_bits=0.
6. len=100 (MAX=64): err_len_clamped pulses once and 2 full beats are emitted. Separately, assert rst during beat 1 of a 2-beat vector: expect tvalid=0 immediately, and after release a fresh vector is sent correctly from beat 0.
